bit_serial_alu_sequencer: RTL and testbench

Multi-cycle controller that runs a WIDTH-bit add/subtract/compare through one single-bit full adder, one bit per cycle, LSB first. It latches operands on a start pulse, steps a bit counter, holds the carry between cycles, and produces a result word plus flags. It trades latency for area: the ALU arithmetic path needs only one full-adder cell.

---
 rtl/bit_serial_alu_sequencer_pkg.sv | 22 ++
 rtl/bit_serial_alu_sequencer_if.sv | 26 ++
 rtl/bit_serial_alu_sequencer_fa.sv | 11 +
 rtl/bit_serial_alu_sequencer.sv | 117 +++++++++++
 tb/tb_bit_serial_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_alu_sequencer_pkg.sv
// rtl/bit_serial_alu_sequencer_pkg.sv - shared opcode/state types for the bit-serial ALU sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_CMP = 2'b11
    } aluOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seqState_t;

    // Subtraction is done as A + ~B + 1, so SUB and CMP feed an inverted B.
    function automatic logic invertsB(input aluOp_t op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/bit_serial_alu_sequencer_if.sv
// rtl/bit_serial_alu_sequencer_if.sv - request/response bundle between a host and the bit-serial ALU
interface bit_serial_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       opSelect;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             carryIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryOut;
    logic             overflow;
    logic             zero;

    modport master (
        output start, opSelect, operandA, operandB, carryIn,
        input  busy, done, result, carryOut, overflow, zero
    );

    modport slave (
        input  start, opSelect, operandA, operandB, carryIn,
        output busy, done, result, carryOut, overflow, zero
    );
endinterface

// File: rtl/bit_serial_alu_sequencer_fa.sv
// rtl/bit_serial_alu_sequencer_fa.sv - single-bit full adder cell used by the serial datapath
module SingleBitFullAdder (
    input  logic a,
    input  logic b,
    input  logic carryIn,
    output logic sum,
    output logic carryOut
);
    assign sum      = a ^ b ^ carryIn;
    assign carryOut = (a & b) | (carryIn & (a ^ b));
endmodule

// File: rtl/bit_serial_alu_sequencer.sv
// rtl/bit_serial_alu_sequencer.sv - WIDTH-bit add/sub/compare run LSB first through one full adder
module bit_serial_alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    bit_serial_alu_sequencer_if.slave aluBus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    seqState_t          state;
    seqState_t          nextState;
    aluOp_t             opReg;
    aluOp_t             opIn;
    logic [WIDTH-1:0]   aShift;
    logic [WIDTH-1:0]   bShift;
    logic [WIDTH-2:0]   sumShift;
    logic [WIDTH-1:0]   sumNext;
    logic               carryReg;
    logic               nonZero;
    logic [CNT_W-1:0]   bitCount;
    logic               sumBit;
    logic               carryBit;
    logic               accept;
    logic               lastBit;

    assign opIn    = aluOp_t'(aluBus.opSelect);
    assign sumNext = {sumBit, sumShift};

    SingleBitFullAdder serialAdder (
        .a        (aShift[0]),
        .b        (bShift[0]),
        .carryIn  (carryReg),
        .sum      (sumBit),
        .carryOut (carryBit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        accept      = 1'b0;
        lastBit     = 1'b0;
        aluBus.busy = 1'b0;
        aluBus.done = 1'b0;
        unique case (state)
            IDLE: begin
                if (aluBus.start) begin
                    accept    = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                aluBus.busy = 1'b1;
                if (bitCount == CNT_W'(WIDTH - 1)) begin
                    lastBit   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                aluBus.busy = 1'b1;
                aluBus.done = 1'b1;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Result and flags are registered on the last RUN edge so they first appear in the done cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opReg           <= OP_ADD;
            aShift          <= '0;
            bShift          <= '0;
            sumShift        <= '0;
            carryReg        <= 1'b0;
            nonZero         <= 1'b0;
            bitCount        <= '0;
            aluBus.result   <= '0;
            aluBus.carryOut <= 1'b0;
            aluBus.overflow <= 1'b0;
            aluBus.zero     <= 1'b0;
        end else if (accept) begin
            opReg    <= opIn;
            aShift   <= aluBus.operandA;
            bShift   <= invertsB(opIn) ? ~aluBus.operandB : aluBus.operandB;
            carryReg <= (opIn == OP_ADC) ? aluBus.carryIn : invertsB(opIn);
            nonZero  <= 1'b0;
            bitCount <= '0;
        end else if (state == RUN) begin
            aShift   <= aShift >> 1;
            bShift   <= bShift >> 1;
            sumShift <= sumNext[WIDTH-1:1];
            carryReg <= carryBit;
            nonZero  <= nonZero | sumBit;
            if (lastBit) begin
                if (opReg != OP_CMP) begin
                    aluBus.result <= sumNext;
                end
                aluBus.carryOut <= carryBit;
                // carryReg here is the carry into the MSB
                aluBus.overflow <= carryReg ^ carryBit;
                aluBus.zero     <= ~(nonZero | sumBit);
            end else begin
                bitCount <= bitCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_serial_alu_sequencer.sv
// tb/tb_bit_serial_alu_sequencer.sv - randomized self-checking bench with a behavioural ALU model
module tb_bit_serial_alu_sequencer;
    localparam int W = 8;

    logic clock;
    logic reset;

    bit_serial_alu_sequencer_if #(.WIDTH(W)) aluBus ();

    bit_serial_alu_sequencer #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .aluBus (aluBus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } flags_t;

    // Arithmetic reference: plain integer add/subtract with range checks for carry and overflow.
    function automatic flags_t refCalc(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic cin);
        int     ua, ub, sa, sb, u, s;
        flags_t f;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'b00:   begin u = ua + ub;            s = sa + sb;            end
            2'b10:   begin u = ua + ub + int'(cin); s = sa + sb + int'(cin); end
            default: begin u = ua - ub;            s = sa - sb;            end
        endcase
        f.res = u[W-1:0];
        f.c   = (op == 2'b01 || op == 2'b11) ? (u >= 0) : (u >= (1 << W));
        f.v   = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        f.z   = (u[W-1:0] == '0);
        return f;
    endfunction

    int           cyc;
    int           acceptEdge;
    bit           active;
    bit           pendCmp;
    flags_t       pend;
    logic [W-1:0] expRes;
    logic         expC, expV, expZ;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc        <= 0;
            acceptEdge <= 0;
            active     <= 1'b0;
            pendCmp    <= 1'b0;
            pend       <= '0;
            expRes     <= '0;
            expC       <= 1'b0;
            expV       <= 1'b0;
            expZ       <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (active && (cyc + 1 - acceptEdge) == W) begin
                if (!pendCmp) expRes <= pend.res;
                expC <= pend.c;
                expV <= pend.v;
                expZ <= pend.z;
            end
            if ((!active || (cyc + 1 - acceptEdge) >= W + 2) && aluBus.start) begin
                active     <= 1'b1;
                acceptEdge <= cyc + 1;
                pendCmp    <= (aluBus.opSelect == 2'b11);
                pend       <= refCalc(aluBus.opSelect, aluBus.operandA, aluBus.operandB, aluBus.carryIn);
            end
        end
    end

    int checks;
    int errors;
    int edgeNum;
    int lastDoneEdge;
    bit doneSeen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic compareAll();
        logic expBusy, expDone;
        expBusy = active && ((cyc - acceptEdge) <= W);
        expDone = active && ((cyc - acceptEdge) == W);
        chk("busy",     32'(aluBus.busy),     32'(expBusy));
        chk("done",     32'(aluBus.done),     32'(expDone));
        chk("result",   32'(aluBus.result),   32'(expRes));
        chk("carryOut", 32'(aluBus.carryOut), 32'(expC));
        chk("overflow", 32'(aluBus.overflow), 32'(expV));
        chk("zero",     32'(aluBus.zero),     32'(expZ));
    endtask

    task automatic tick();
        @(negedge clock);
        compareAll();
        doneSeen = aluBus.done;
        if (aluBus.done) lastDoneEdge = edgeNum;
        @(posedge clock);
        edgeNum++;
        #1;
    endtask

    task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output int lat);
        int acc;
        bit got;
        aluBus.opSelect = op;
        aluBus.operandA = a;
        aluBus.operandB = b;
        aluBus.carryIn  = cin;
        aluBus.start    = 1'b1;
        tick();
        acc = edgeNum;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < W + 6; i++) begin
            aluBus.start    = 1'($urandom_range(0, 1));
            aluBus.opSelect = 2'($urandom_range(0, 3));
            aluBus.operandA = W'($urandom);
            aluBus.operandB = W'($urandom);
            aluBus.carryIn  = 1'($urandom_range(0, 1));
            tick();
            if (doneSeen) begin
                got = 1'b1;
                break;
            end
        end
        aluBus.start = 1'b0;
        if (!got) chk("doneTimeout", 32'd0, 32'd1);
        else lat = lastDoneEdge - acc;
    endtask

    task automatic pin(input string name, input logic [W-1:0] r, input logic c,
                       input logic v, input logic z);
        chk({name, ".result"},   32'(aluBus.result),   32'(r));
        chk({name, ".carryOut"}, 32'(aluBus.carryOut), 32'(c));
        chk({name, ".overflow"}, 32'(aluBus.overflow), 32'(v));
        chk({name, ".zero"},     32'(aluBus.zero),     32'(z));
    endtask

    initial begin
        int lat;
        int d1, d2;
        checks          = 0;
        errors          = 0;
        edgeNum         = 0;
        lastDoneEdge    = 0;
        doneSeen        = 1'b0;
        reset           = 1'b1;
        aluBus.start    = 1'b0;
        aluBus.opSelect = 2'b00;
        aluBus.operandA = '0;
        aluBus.operandB = '0;
        aluBus.carryIn  = 1'b0;

        repeat (2) tick();
        chk("resetBusy", 32'(aluBus.busy), 32'd0);
        chk("resetDone", 32'(aluBus.done), 32'd0);
        pin("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) tick();

        // done lands in the cycle after edge WIDTH counted from the accepting edge
        runOp(2'b00, 8'h7F, 8'h01, 1'b0, lat);
        chk("addLatency", 32'(lat), 32'(W));
        pin("add", 8'h80, 1'b0, 1'b1, 1'b0);

        runOp(2'b01, 8'h05, 8'h05, 1'b0, lat);
        pin("sub", 8'h00, 1'b1, 1'b0, 1'b1);

        runOp(2'b10, 8'hFF, 8'h00, 1'b1, lat);
        pin("adc", 8'h00, 1'b1, 1'b0, 1'b1);

        runOp(2'b11, 8'h03, 8'h04, 1'b0, lat);
        pin("cmp", 8'h00, 1'b0, 1'b0, 1'b0);

        // start held high throughout: the second operation starts two edges after done
        aluBus.opSelect = 2'b00;
        aluBus.operandA = 8'h21;
        aluBus.operandB = 8'h13;
        aluBus.carryIn  = 1'b0;
        aluBus.start    = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 3 * W + 10; i++) begin
            tick();
            if (doneSeen) begin
                if (d1 < 0) d1 = lastDoneEdge;
                else begin
                    d2 = lastDoneEdge;
                    break;
                end
            end
        end
        aluBus.start = 1'b0;
        chk("holdGap", 32'(d2 - d1), 32'(W + 2));
        pin("hold", 8'h34, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // reset during the fourth RUN cycle aborts without a done pulse
        aluBus.opSelect = 2'b00;
        aluBus.operandA = 8'h55;
        aluBus.operandB = 8'h0F;
        aluBus.start    = 1'b1;
        tick();
        aluBus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("abortBusy", 32'(aluBus.busy), 32'd0);
        chk("abortDone", 32'(aluBus.done), 32'd0);
        pin("abort", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (W + 3) tick();
        runOp(2'b00, 8'h01, 8'h01, 1'b0, lat);
        pin("afterReset", 8'h02, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            runOp(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), lat);
            chk("randLatency", 32'(lat), 32'(W));
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
